pcie_tlp_cpl_engine: RTL and testbench

Parametrised PCIe-style transaction-layer request engine. It is the verification DUT used in place of the always-ready TLP sink. It buffers incoming TLP-like requests in a FIFO, classifies them as posted or non-posted, and tracks outstanding tags. For every non-posted request it returns a completion with status after a programmable latency, and it keeps saturating statistics. Educational model only; no data payload path.

---
 rtl/pcie_tlp_pkg.sv | 43 ++++
 rtl/pcie_tlp_fifo.sv | 54 +++++
 rtl/pcie_tlp_cpl_engine.sv | 207 ++++++++++++++++++++
 tb/tb_pcie_tlp_cpl_engine.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - shared types and helpers for the TLP completion engine
package pcie_tlp_pkg;

  // Storage widths for a queued request; the engine zero-extends into these
  // and truncates back to its own parameter widths.
  localparam int REQ_ADDR_MAX = 64;
  localparam int REQ_LEN_MAX  = 16;
  localparam int REQ_TAG_MAX  = 8;

  typedef enum logic [2:0] {
    TLP_MRD   = 3'b000,
    TLP_MWR   = 3'b001,
    TLP_CFGRD = 3'b010,
    TLP_CFGWR = 3'b011
  } tlp_type_e;

  typedef enum logic [1:0] {
    CPL_SC = 2'b00,
    CPL_UR = 2'b01,
    CPL_CA = 2'b10
  } cpl_status_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_SEND = 2'b10
  } fsm_state_e;

  // typ stays a raw code so unsupported encodings survive the queue intact
  typedef struct packed {
    logic [2:0]              typ;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_LEN_MAX-1:0]  len;
    logic [REQ_TAG_MAX-1:0]  tag;
  } tlp_req_t;

  // Only memory writes are posted; everything else, unsupported codes
  // included, owes the requester a completion.
  function automatic logic is_non_posted(input logic [2:0] typ);
    return typ != TLP_MWR;
  endfunction

endpackage

// File: rtl/pcie_tlp_fifo.sv
// rtl/pcie_tlp_fifo.sv - synchronous request FIFO with full/empty flags
module pcie_tlp_fifo
  import pcie_tlp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  tlp_req_t din,
  input  logic     pop,
  output tlp_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  tlp_req_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pcie_tlp_cpl_engine.sv
// rtl/pcie_tlp_cpl_engine.sv - TLP request sink with tag tracking, delayed completions and stats
module pcie_tlp_cpl_engine
  import pcie_tlp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 10,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int CPL_LAT    = 4,
  parameter int MAX_LEN_DW = 128,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tlp_valid,
  output logic              tlp_ready,
  input  logic [2:0]        tlp_type,
  input  logic [ADDR_W-1:0] tlp_addr,
  input  logic [LEN_W-1:0]  tlp_len_dw,
  input  logic [TAG_W-1:0]  tlp_tag,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [1:0]        cpl_status,
  output logic [LEN_W-1:0]  cpl_len_dw,
  output logic              err_dup_tag,
  output logic [CNT_W-1:0]  cnt_posted,
  output logic [CNT_W-1:0]  cnt_np,
  output logic [CNT_W-1:0]  cnt_err
);

  localparam int NTAGS = 2 ** TAG_W;
  localparam int CW    = (CPL_LAT < 2) ? 1 : $clog2(CPL_LAT + 1);

  logic             init_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_settled;
  tlp_req_t         req_in;
  tlp_req_t         head;
  logic [NTAGS-1:0] tag_table;
  logic             accept;
  logic             in_np;
  logic             cpl_fire;
  logic             tag_busy;
  logic             dup_drop;
  fsm_state_e       state;
  fsm_state_e       state_next;
  logic [CW-1:0]    wait_cnt;
  logic             head_np;
  logic [LEN_W-1:0] head_len;
  logic [TAG_W-1:0] head_tag;
  cpl_status_e      head_status;
  logic [LEN_W-1:0] head_cpl_len;
  logic [1:0]       posted_inc;
  logic [1:0]       np_inc;
  logic [1:0]       err_inc;
  logic             unused_head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Ingress: a non-posted tag is busy unless this same edge releases it
  assign tlp_ready = init_done & ~fifo_full;
  assign accept    = tlp_valid & tlp_ready;
  assign in_np     = is_non_posted(tlp_type);
  assign cpl_fire  = cpl_valid & cpl_ready;
  assign tag_busy  = tag_table[tlp_tag] & ~(cpl_fire && (cpl_tag == tlp_tag));
  assign fifo_push = accept & (~in_np | ~tag_busy);
  assign dup_drop  = accept & in_np & tag_busy;

  // Pack the incoming request into the queue record
  always_comb begin
    req_in      = '0;
    req_in.typ  = tlp_type;
    req_in.addr = REQ_ADDR_MAX'(tlp_addr);
    req_in.len  = REQ_LEN_MAX'(tlp_len_dw);
    req_in.tag  = REQ_TAG_MAX'(tlp_tag);
  end

  pcie_tlp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (req_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_np     = is_non_posted(head.typ);
  assign head_len    = head.len[LEN_W-1:0];
  assign head_tag    = head.tag[TAG_W-1:0];
  // Address is carried for completeness but never inspected
  assign unused_head = ^head;

  // Completion status and returned length for the FIFO head
  always_comb begin
    head_status  = CPL_SC;
    head_cpl_len = '0;
    case (head.typ)
      TLP_MRD: begin
        if (head_len == '0 || 32'(head_len) > 32'(MAX_LEN_DW)) head_status = CPL_CA;
        else head_cpl_len = head_len;
      end
      TLP_CFGRD: begin
        if (head_len != LEN_W'(1)) head_status = CPL_CA;
        else head_cpl_len = LEN_W'(1);
      end
      TLP_CFGWR: begin
        if (head_len != LEN_W'(1)) head_status = CPL_CA;
      end
      TLP_MWR: head_status = CPL_SC;
      default: head_status = CPL_UR;
    endcase
  end

  // Ready comes up one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  // An entry is popped only once it has sat in the FIFO for a full cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) head_settled <= 1'b0;
    else        head_settled <= ~fifo_empty;
  end

  // Outstanding-tag table: release first, then set, so same-tag reuse ends set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_table <= '0;
    end else begin
      if (cpl_fire)            tag_table[cpl_tag] <= 1'b0;
      if (fifo_push && in_np)  tag_table[tlp_tag] <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (fifo_pop && head_np) state_next = (CPL_LAT == 0) ? ST_SEND : ST_WAIT;
      ST_WAIT: if (wait_cnt == CW'(1)) state_next = ST_SEND;
      ST_SEND: if (cpl_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpl_valid = (state == ST_SEND);
    fifo_pop  = (state == ST_IDLE) & ~fifo_empty & head_settled;
  end

  // Latency counter and completion hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      cpl_tag    <= '0;
      cpl_status <= '0;
      cpl_len_dw <= '0;
    end else if (fifo_pop && head_np) begin
      wait_cnt   <= CW'(CPL_LAT);
      cpl_tag    <= head_tag;
      cpl_status <= head_status;
      cpl_len_dw <= head_cpl_len;
    end else if (state == ST_WAIT) begin
      wait_cnt   <= wait_cnt - CW'(1);
    end
  end

  assign posted_inc = {1'b0, fifo_pop & ~head_np};
  assign np_inc     = {1'b0, cpl_fire};
  assign err_inc    = {1'b0, dup_drop} + {1'b0, cpl_fire & (cpl_status != CPL_SC)};

  // Duplicate-tag pulse and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_dup_tag <= 1'b0;
      cnt_posted  <= '0;
      cnt_np      <= '0;
      cnt_err     <= '0;
    end else begin
      err_dup_tag <= dup_drop;
      cnt_posted  <= sat_add(cnt_posted, posted_inc);
      cnt_np      <= sat_add(cnt_np, np_inc);
      cnt_err     <= sat_add(cnt_err, err_inc);
    end
  end

endmodule

// File: tb/tb_pcie_tlp_cpl_engine.sv
// tb/tb_pcie_tlp_cpl_engine.sv - directed vector bench for the TLP completion engine
module tb_pcie_tlp_cpl_engine;
  import pcie_tlp_pkg::*;

  localparam int CPL_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        tlp_valid;
  logic        tlp_ready;
  logic [2:0]  tlp_type;
  logic [31:0] tlp_addr;
  logic [9:0]  tlp_len_dw;
  logic [4:0]  tlp_tag;
  logic        cpl_valid;
  logic        cpl_ready;
  logic [4:0]  cpl_tag;
  logic [1:0]  cpl_status;
  logic [9:0]  cpl_len_dw;
  logic        err_dup_tag;
  logic [15:0] cnt_posted;
  logic [15:0] cnt_np;
  logic [15:0] cnt_err;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int last_acc = 0;
  int dup_pulses = 0;
  int exp_posted = 0;
  int exp_np = 0;
  int exp_err = 0;

  typedef struct {
    logic [2:0] typ;
    logic [9:0] len;
    logic [4:0] tag;
    logic [1:0] st;
    logic [9:0] cl;
  } vec_t;

  vec_t        vecs [14];
  logic [4:0]  g_tag;
  logic [1:0]  g_st;
  logic [9:0]  g_len;
  int          g_at;
  int          acc0;
  int          prev_at;
  int          dup0;
  logic        seen;

  pcie_tlp_cpl_engine #(.CPL_LAT(CPL_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tlp_valid   (tlp_valid),
    .tlp_ready   (tlp_ready),
    .tlp_type    (tlp_type),
    .tlp_addr    (tlp_addr),
    .tlp_len_dw  (tlp_len_dw),
    .tlp_tag     (tlp_tag),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_tag     (cpl_tag),
    .cpl_status  (cpl_status),
    .cpl_len_dw  (cpl_len_dw),
    .err_dup_tag (err_dup_tag),
    .cnt_posted  (cnt_posted),
    .cnt_np      (cnt_np),
    .cnt_err     (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err_dup_tag === 1'b1) dup_pulses <= dup_pulses + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic send(input logic [2:0] t, input logic [9:0] l, input logic [4:0] g);
    int n;
    n = 0;
    tlp_valid = 1'b1; tlp_type = t; tlp_len_dw = l; tlp_tag = g; tlp_addr = $urandom;
    while (tlp_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (tlp_ready !== 1'b1) check("send_ready_timeout", 32'(tlp_ready), 32'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    tlp_valid = 1'b0;
  endtask

  task automatic wait_cpl(output logic [4:0] tg, output logic [1:0] st, output logic [9:0] ln, output int at);
    int n;
    n = 0;
    while (cpl_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("cpl_seen", 32'(cpl_valid), 32'd1);
    tg = cpl_tag; st = cpl_status; ln = cpl_len_dw; at = cyc;
    @(posedge clk); #1;
  endtask

  task automatic watch_quiet(input int cycles, input string nm);
    logic s;
    s = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      s = s | (cpl_valid === 1'b1);
    end
    check(nm, 32'(s), 32'd0);
  endtask

  initial begin
    // typ, len, tag, expected status, expected completion length
    vecs[0]  = '{3'b001, 10'd4,   5'd3,  2'b00, 10'd0};
    vecs[1]  = '{3'b000, 10'd16,  5'd5,  2'b00, 10'd16};
    vecs[2]  = '{3'b000, 10'd128, 5'd3,  2'b00, 10'd128};
    vecs[3]  = '{3'b000, 10'd129, 5'd4,  2'b10, 10'd0};
    vecs[4]  = '{3'b000, 10'd0,   5'd6,  2'b10, 10'd0};
    vecs[5]  = '{3'b110, 10'd4,   5'd7,  2'b01, 10'd0};
    vecs[6]  = '{3'b010, 10'd1,   5'd8,  2'b00, 10'd1};
    vecs[7]  = '{3'b010, 10'd2,   5'd9,  2'b10, 10'd0};
    vecs[8]  = '{3'b011, 10'd1,   5'd10, 2'b00, 10'd0};
    vecs[9]  = '{3'b011, 10'd3,   5'd11, 2'b10, 10'd0};
    vecs[10] = '{3'b111, 10'd1,   5'd12, 2'b01, 10'd0};
    vecs[11] = '{3'b000, 10'd200, 5'd13, 2'b10, 10'd0};
    vecs[12] = '{3'b100, 10'd1,   5'd14, 2'b01, 10'd0};
    vecs[13] = '{3'b001, 10'd0,   5'd15, 2'b00, 10'd0};

    rst_n = 1'b0; tlp_valid = 1'b0; tlp_type = '0; tlp_addr = '0;
    tlp_len_dw = '0; tlp_tag = '0; cpl_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tlp_ready", 32'(tlp_ready), 0);
    check("rst_cpl_valid", 32'(cpl_valid), 0);
    check("rst_cpl_fields", {cpl_tag, cpl_status, cpl_len_dw}, 0);
    check("rst_err_dup", 32'(err_dup_tag), 0);
    check("rst_counters", {cnt_posted, cnt_np} | 32'(cnt_err), 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(tlp_ready), 0);
    @(posedge clk); #1;
    check("ready_after_first_edge", 32'(tlp_ready), 1);

    // Single-request vectors
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].typ, vecs[i].len, vecs[i].tag);
      acc0 = last_acc;
      if (!is_non_posted(vecs[i].typ)) begin
        exp_posted++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check($sformatf("v%0d_cnt_posted", i), 32'(cnt_posted), exp_posted);
        watch_quiet(10, $sformatf("v%0d_posted_no_cpl", i));
      end else begin
        wait_cpl(g_tag, g_st, g_len, g_at);
        exp_np++;
        if (vecs[i].st != 2'b00) exp_err++;
        check($sformatf("v%0d_latency", i), g_at - acc0, 2 + CPL_LAT);
        check($sformatf("v%0d_tag", i), 32'(g_tag), 32'(vecs[i].tag));
        check($sformatf("v%0d_status", i), 32'(g_st), 32'(vecs[i].st));
        check($sformatf("v%0d_len", i), 32'(g_len), 32'(vecs[i].cl));
        check($sformatf("v%0d_cnt_np", i), 32'(cnt_np), exp_np);
        check($sformatf("v%0d_cnt_err", i), 32'(cnt_err), exp_err);
      end
    end

    // Back-to-back error requests complete in order at full throughput
    send(3'b110, 10'd4,   5'd1);
    send(3'b000, 10'd0,   5'd2);
    send(3'b000, 10'd200, 5'd3);
    send(3'b010, 10'd2,   5'd4);
    prev_at = 0;
    for (int i = 0; i < 4; i++) begin
      wait_cpl(g_tag, g_st, g_len, g_at);
      check($sformatf("seq%0d_tag", i), 32'(g_tag), i + 1);
      check($sformatf("seq%0d_status", i), 32'(g_st), (i == 0) ? 32'd1 : 32'd2);
      check($sformatf("seq%0d_len", i), 32'(g_len), 0);
      if (i > 0) check($sformatf("seq%0d_spacing", i), g_at - prev_at, CPL_LAT + 2);
      prev_at = g_at;
    end
    exp_np += 4; exp_err += 4;
    check("seq_cnt_err", 32'(cnt_err), exp_err);
    check("seq_cnt_np", 32'(cnt_np), exp_np);

    // Duplicate outstanding tag is dropped with a single pulse
    dup0 = dup_pulses;
    send(3'b000, 10'd2, 5'd7);
    acc0 = last_acc;
    send(3'b000, 10'd2, 5'd7);
    check("dup_pulse_high", 32'(err_dup_tag), 1);
    @(posedge clk); #1;
    check("dup_pulse_low", 32'(err_dup_tag), 0);
    wait_cpl(g_tag, g_st, g_len, g_at);
    check("dup_cpl_latency", g_at - acc0, 2 + CPL_LAT);
    check("dup_cpl_fields", {g_tag, g_st, g_len}, {5'd7, 2'b00, 10'd2});
    watch_quiet(15, "dup_single_cpl");
    check("dup_pulse_count", dup_pulses - dup0, 1);
    exp_np += 1; exp_err += 1;
    check("dup_cnt_err", 32'(cnt_err), exp_err);
    check("dup_cnt_np", 32'(cnt_np), exp_np);

    // Full backpressure: eight queued plus one parked in SEND
    cpl_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(3'b000, 10'(i + 1), 5'(i));
    check("bp_ready_low_when_full", 32'(tlp_ready), 0);
    repeat (5) begin
      check("bp_stall_stable", {cpl_valid, cpl_tag, cpl_status, cpl_len_dw}, {1'b1, 5'd0, 2'b00, 10'd1});
      @(posedge clk); #1;
    end
    cpl_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_cpl(g_tag, g_st, g_len, g_at);
      check($sformatf("bp%0d_fields", i), {g_tag, g_st, g_len}, {5'(i), 2'b00, 10'(i + 1)});
    end
    exp_np += 9;
    check("bp_cnt_np", 32'(cnt_np), exp_np);
    check("bp_ready_back", 32'(tlp_ready), 1);

    // Asynchronous reset while waiting, then the same tag completes normally
    send(3'b000, 10'd8, 5'd20);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst_cpl_valid", 32'(cpl_valid), 0);
    check("arst_counters", {cnt_posted, cnt_np} | 32'(cnt_err), 0);
    check("arst_tlp_ready", 32'(tlp_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_ready_before_edge", 32'(tlp_ready), 0);
    @(posedge clk); #1;
    check("arst_ready_after_edge", 32'(tlp_ready), 1);
    check("arst_no_stale_cpl", 32'(cpl_valid), 0);
    send(3'b000, 10'd8, 5'd20);
    acc0 = last_acc;
    wait_cpl(g_tag, g_st, g_len, g_at);
    check("arst_cpl_latency", g_at - acc0, 2 + CPL_LAT);
    check("arst_cpl_fields", {g_tag, g_st, g_len}, {5'd20, 2'b00, 10'd8});
    check("arst_cnt_np", 32'(cnt_np), 1);
    check("arst_cnt_err", 32'(cnt_err), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
